// File: rtl/ams_adc_seq.sv
// ams_adc_seq: time-shares the 1-bit comparator ADC across NUM_CH selections.
// For each enabled channel it drives the select, waits the settle time, then
// samples and counts the ones. It emits one result beat per channel and a pulse
// at the end of each sweep. Sweeps run once, or repeat every period_i cycles.
// Optional build macro AMS_ADC_SEQ_SYNC_EN: adds a 2-flop synchronizer on
// adc_out_i and lengthens SETTLE by 2 cycles so samples stay aligned.
module ams_adc_seq #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic              continuous_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic [7:0]        settle_i,
  input  logic [ACC_W-1:0]  num_samples_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic              adc_out_i,
  output logic [SEL_W-1:0]  adc_sel_o,
  output logic              res_valid_o,
  output logic [SEL_W-1:0]  res_ch_o,
  output logic [ACC_W-1:0]  res_count_o,
  output logic              sweep_done_o,
  output logic              busy_o
);

  // One timer serves both the settle and the sample phase.
  localparam int TMR_W = (ACC_W > 9) ? ACC_W : 9;

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, STORE, WAIT} state_t;

  state_t             state, state_next;
  logic [NUM_CH-1:0]  mask_q, mask_src;
  logic [7:0]         settle_q, settle_src;
  logic [ACC_W-1:0]   nsamp_q;
  logic [CNT_W-1:0]   period_q;
  logic               cont_q;
  logic [SEL_W-1:0]   sel, res_ch, first_ch, next_ch;
  logic               first_found, has_next;
  logic [TMR_W-1:0]   tmr, settle_load, sample_load;
  logic [ACC_W-1:0]   acc, res_count;
  logic [CNT_W-1:0]   cnt;
  logic               res_valid, sweep_done, wait_done, new_sweep, adc_bit;

`ifdef AMS_ADC_SEQ_SYNC_EN
  localparam logic [TMR_W-1:0] SETTLE_XTRA = TMR_W'(2);
  logic [1:0] sync;

  // Two-flop synchronizer for the comparator output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync <= '0;
    else         sync <= {sync[0], adc_out_i};
  end
  assign adc_bit = sync[1];
`else
  localparam logic [TMR_W-1:0] SETTLE_XTRA = '0;
  assign adc_bit = adc_out_i;
`endif

  // Channel selection: first masked channel, next masked channel above the current select
  always_comb begin
    mask_src    = (state == IDLE) ? ch_mask_i : mask_q;
    first_ch    = '0;
    first_found = 1'b0;
    next_ch     = '0;
    has_next    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (mask_src[i] && !first_found) begin
        first_ch    = SEL_W'(i);
        first_found = 1'b1;
      end
      if (mask_q[i] && (i > 32'(sel)) && !has_next) begin
        next_ch  = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  // Timer reload values and the sweep-period test
  always_comb begin
    settle_src  = (state == IDLE) ? settle_i : settle_q;
    settle_load = TMR_W'(settle_src) + SETTLE_XTRA;
    sample_load = (nsamp_q == '0) ? '0 : TMR_W'(nsamp_q) - TMR_W'(1);
    wait_done   = ((CNT_W+1)'(cnt) + (CNT_W+1)'(1)) >= (CNT_W+1)'(period_q);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a low enable_i overrides every transition out of a busy state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i && enable_i && |ch_mask_i) state_next = SETTLE;
      SETTLE:  if (tmr == '0) state_next = SAMPLE;
      SAMPLE:  if (tmr == '0) state_next = STORE;
      STORE:   state_next = has_next ? SETTLE : (cont_q ? WAIT : IDLE);
      WAIT:    if (wait_done) state_next = SETTLE;
      default: state_next = IDLE;
    endcase
    if (!enable_i && state != IDLE) state_next = IDLE;
  end

  assign new_sweep = (state_next == SETTLE) && (state == IDLE || state == WAIT);

  // Datapath: config latch, timers, accumulator, select and registered result strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q      <= '0;
      settle_q    <= '0;
      nsamp_q     <= '0;
      period_q    <= '0;
      cont_q      <= 1'b0;
      sel         <= '0;
      tmr         <= '0;
      acc         <= '0;
      cnt         <= '0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_count   <= '0;
      sweep_done  <= 1'b0;
    end else begin
      res_valid  <= 1'b0;
      sweep_done <= 1'b0;
      if (state == IDLE && state_next == SETTLE) begin
        mask_q   <= ch_mask_i;
        settle_q <= settle_i;
        nsamp_q  <= num_samples_i;
        period_q <= period_i;
        cont_q   <= continuous_i;
      end
      if (new_sweep)                       cnt <= '0;
      else if (state != IDLE && cnt != '1) cnt <= cnt + CNT_W'(1);
      case (state)
        SETTLE: tmr <= (state_next == SAMPLE) ? sample_load : tmr - TMR_W'(1);
        SAMPLE: begin
          acc <= acc + ACC_W'(adc_bit);
          tmr <= tmr - TMR_W'(1);
          if (state_next == STORE) begin
            res_valid  <= 1'b1;
            res_ch     <= sel;
            res_count  <= acc + ACC_W'(adc_bit);
            sweep_done <= !has_next;
          end
        end
        default: ;
      endcase
      // Entry into SETTLE overrides the timer update above
      if (state_next == SETTLE && state != SETTLE) begin
        acc <= '0;
        tmr <= settle_load;
        sel <= (state == STORE) ? next_ch : first_ch;
      end
    end
  end

  assign adc_sel_o    = sel;
  assign res_valid_o  = res_valid;
  assign res_ch_o     = res_ch;
  assign res_count_o  = res_count;
  assign sweep_done_o = sweep_done;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_ams_adc_seq.sv
// Testbench for ams_adc_seq. A sweep-schedule model predicts, for every cycle,
// the result beats, sweep_done, busy and the select from the latched
// configuration and the recorded comparator input sequence.
module tb_ams_adc_seq;
  localparam int NUM_CH = 4, SEL_W = 2, ACC_W = 8, CNT_W = 16, MAXLEN = 700;
  localparam int NONE = 1000000;
`ifdef AMS_ADC_SEQ_SYNC_EN
  localparam int LAT = 2, XS = 2;
`else
  localparam int LAT = 0, XS = 0;
`endif

  logic              clk, rst_ni, enable_i, start_i, continuous_i, adc_out_i;
  logic [NUM_CH-1:0] ch_mask_i;
  logic [7:0]        settle_i;
  logic [ACC_W-1:0]  num_samples_i;
  logic [CNT_W-1:0]  period_i;
  logic [SEL_W-1:0]  adc_sel_o, res_ch_o;
  logic              res_valid_o, sweep_done_o, busy_o;
  logic [ACC_W-1:0]  res_count_o;

  ams_adc_seq #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .start_i(start_i),
    .continuous_i(continuous_i), .ch_mask_i(ch_mask_i), .settle_i(settle_i),
    .num_samples_i(num_samples_i), .period_i(period_i), .adc_out_i(adc_out_i),
    .adc_sel_o(adc_sel_o), .res_valid_o(res_valid_o), .res_ch_o(res_ch_o),
    .res_count_o(res_count_o), .sweep_done_o(sweep_done_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int sel_cur = 0;
  bit adc_v[MAXLEN];
  bit e_valid[MAXLEN], e_done[MAXLEN], e_busy[MAXLEN];
  int e_ch[MAXLEN], e_cnt[MAXLEN], e_sel[MAXLEN];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Walk the sweeps channel by channel: settle L cycles, n sample cycles, one store cycle.
  task automatic build_model(input int mask, input int settle, input int ns, input int period,
                             input bit cont, input int abort_at, input int len);
    int sel_set[MAXLEN];
    int L, n, s, t, e, nxt, cnt;
    bit stop, complete;
    for (int c = 0; c < len; c++) begin
      e_valid[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_ch[c] = 0; e_cnt[c] = 0;
      sel_set[c] = -1;
    end
    if (mask != 0) begin
      L = settle + 1 + XS;
      n = (ns == 0) ? 1 : ns;
      s = 1;
      stop = 0;
      while (!stop) begin
        t = s; e = s; complete = 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (((mask >> ch) & 1) != 0 && complete) begin
            if (t > abort_at || t >= len) complete = 0;
            else begin
              sel_set[t] = ch;
              e = t + L + n;
              if (e > abort_at || e >= len) complete = 0;
              else begin
                cnt = 0;
                for (int c = t + L; c < e; c++) cnt += int'(adc_v[c - LAT]);
                e_valid[e] = 1; e_ch[e] = ch; e_cnt[e] = cnt;
                t = e + 1;
              end
            end
          end
        end
        if (complete) e_done[e] = 1;
        if (!complete)  nxt = len;
        else if (cont)  nxt = (e + 2 > s + period) ? e + 2 : s + period;
        else            nxt = e + 1;
        for (int c = s; c < nxt && c < len && c <= abort_at; c++) e_busy[c] = 1;
        if (!complete || !cont) stop = 1;
        else begin
          s = nxt;
          if (s >= len) stop = 1;
        end
      end
    end
    for (int c = 0; c < len; c++) begin
      if (sel_set[c] >= 0) sel_cur = sel_set[c];
      e_sel[c] = sel_cur;
    end
  endtask

  // Cycle 0 carries the start pulse; config inputs are scrambled afterwards to show they are latched.
  task automatic run_scn(input string name, input int mask, input int settle, input int ns,
                         input int period, input bit cont, input int abort_at, input int len,
                         input int mode);
    for (int c = 0; c < len; c++) begin
      case (mode)
        1:       adc_v[c] = 1;
        2:       adc_v[c] = bit'(c % 2);
        3:       adc_v[c] = (c < 9);
        default: adc_v[c] = bit'($urandom % 2);
      endcase
    end
    build_model(mask, settle, ns, period, cont, abort_at, len);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        ch_mask_i = NUM_CH'(mask); settle_i = 8'(settle); num_samples_i = ACC_W'(ns);
        period_i = CNT_W'(period); continuous_i = cont; start_i = 1'b1; enable_i = 1'b1;
      end else begin
        ch_mask_i = NUM_CH'($urandom); settle_i = 8'($urandom); num_samples_i = ACC_W'($urandom);
        period_i = CNT_W'($urandom); continuous_i = 1'($urandom);
        start_i = (k == abort_at) && e_busy[k];
        enable_i = (k < abort_at);
      end
      adc_out_i = adc_v[k];
      @(negedge clk);
      check_eq($sformatf("%s busy@%0d", name, k), 32'(busy_o), 32'(e_busy[k]));
      check_eq($sformatf("%s valid@%0d", name, k), 32'(res_valid_o), 32'(e_valid[k]));
      check_eq($sformatf("%s done@%0d", name, k), 32'(sweep_done_o), 32'(e_done[k]));
      check_eq($sformatf("%s sel@%0d", name, k), 32'(adc_sel_o), 32'(e_sel[k]));
      if (e_valid[k]) begin
        check_eq($sformatf("%s ch@%0d", name, k), 32'(res_ch_o), 32'(e_ch[k]));
        check_eq($sformatf("%s count@%0d", name, k), 32'(res_count_o), 32'(e_cnt[k]));
      end
    end
    start_i = 1'b0;
  endtask

  initial begin
    int m, st, ns, per, ab, len;
    bit cn;
    rst_ni = 1'b0; enable_i = 1'b0; start_i = 1'b0; continuous_i = 1'b0; adc_out_i = 1'b0;
    ch_mask_i = '0; settle_i = '0; num_samples_i = '0; period_i = '0;
    #12;
    check_eq("reset busy", 32'(busy_o), 0);
    check_eq("reset valid", 32'(res_valid_o), 0);
    check_eq("reset done", 32'(sweep_done_o), 0);
    check_eq("reset sel", 32'(adc_sel_o), 0);
    check_eq("reset count", 32'(res_count_o), 0);
    #10 rst_ni = 1'b1;

    run_scn("two_ch",  5, 2,   4,  0, 0, NONE,  25, 3);
    run_scn("alt",     2, 0,  10,  0, 0, NONE,  20, 2);
    run_scn("cont20",  1, 0,   2, 20, 1,   50,  55, 0);
    run_scn("cont3",   1, 0,   2,  3, 1,   14,  20, 0);
    run_scn("ns0",     8, 1,   0,  0, 0, NONE,  12, 0);
    run_scn("mask0",   0, 0,   3,  0, 0, NONE,   8, 0);
    run_scn("abort",   5, 2,   4,  0, 0,   13,  20, 3);
    run_scn("again",   5, 2,   4,  0, 0, NONE,  25, 3);
    run_scn("ns255",   4, 0, 255,  0, 0, NONE, 265, 1);

    // Asynchronous reset in the middle of SAMPLE
    @(posedge clk); #1;
    ch_mask_i = 4'b1000; settle_i = 0; num_samples_i = 20; continuous_i = 0;
    enable_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check_eq("pre-rst busy", 32'(busy_o), 1);
    check_eq("pre-rst sel", 32'(adc_sel_o), 3);
    check_eq("pre-rst count", 32'(res_count_o), 255);
    rst_ni = 1'b0;
    #1;
    check_eq("rst busy", 32'(busy_o), 0);
    check_eq("rst sel", 32'(adc_sel_o), 0);
    check_eq("rst count", 32'(res_count_o), 0);
    check_eq("rst valid", 32'(res_valid_o), 0);
    check_eq("rst done", 32'(sweep_done_o), 0);
    @(posedge clk); #3 rst_ni = 1'b1;
    sel_cur = 0;
    run_scn("post_rst", 5, 2, 4, 0, 0, NONE, 25, 3);

    for (int r = 0; r < 12; r++) begin
      m   = int'($urandom % 16);
      st  = int'($urandom % 6);
      ns  = int'($urandom % 13);
      per = int'($urandom % 40);
      cn  = 1'($urandom);
      if (cn) begin
        ab  = 20 + int'($urandom % 100);
        len = ab + 5;
      end else begin
        ab  = ($urandom % 2 == 1) ? int'($urandom % 60) + 1 : NONE;
        len = 100;
      end
      run_scn($sformatf("rnd%0d", r), m, st, ns, per, cn, ab, len, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
